// File: rtl/vregfile_sb.sv
// Vector register file: per-lane masked writes on two ports, bypassed reads,
// and a pending-write scoreboard for late results arriving on port B.
module vregfile_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int VLEN       = 16,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 32,
  parameter int NUM_RD     = 3,
  parameter int ZERO_REG   = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wen_a,
  input  logic [ADDR_WIDTH-1:0]             addr_wa,
  input  logic [VLEN-1:0]                   mask_wa,
  input  logic [VLEN*DATA_WIDTH-1:0]        data_wa,
  input  logic                              wen_b,
  input  logic [ADDR_WIDTH-1:0]             addr_wb,
  input  logic [VLEN-1:0]                   mask_wb,
  input  logic [VLEN*DATA_WIDTH-1:0]        data_wb,
  input  logic                              rsv_en,
  input  logic [ADDR_WIDTH-1:0]             rsv_addr,
  output logic                              rsv_conflict,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]      addr_r,
  output logic [NUM_RD*VLEN*DATA_WIDTH-1:0] data_r,
  output logic [NUM_RD-1:0]                 busy_r
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = ADDR_WIDTH;

  logic [DW-1:0]    r_mem [DEPTH][VLEN];
  logic [DEPTH-1:0] r_pend;

  // Out-of-range and hardwired-zero registers are neither stored nor tracked.
  function automatic logic f_ok(input logic [AW-1:0] a);
    return (int'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  logic             w_a_ok;
  logic             w_b_ok;
  logic             w_rsv_ok;
  logic [DEPTH-1:0] w_a_sel;
  logic [DEPTH-1:0] w_b_sel;
  logic [DEPTH-1:0] w_rsv_sel;

  assign w_a_ok   = wen_a  && f_ok(addr_wa);
  assign w_b_ok   = wen_b  && f_ok(addr_wb);
  assign w_rsv_ok = rsv_en && f_ok(rsv_addr);

  always_comb begin
    w_a_sel   = '0;
    w_b_sel   = '0;
    w_rsv_sel = '0;
    for (int r = 0; r < DEPTH; r++) begin
      w_a_sel[r]   = w_a_ok   && (int'(addr_wa)  == r);
      w_b_sel[r]   = w_b_ok   && (int'(addr_wb)  == r);
      w_rsv_sel[r] = w_rsv_ok && (int'(rsv_addr) == r);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend <= '0;
      for (int r = 0; r < DEPTH; r++) begin
        for (int l = 0; l < VLEN; l++) begin
          r_mem[r][l] <= '0;
        end
      end
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        for (int l = 0; l < VLEN; l++) begin
          if (w_b_sel[r] && mask_wb[l]) begin
            r_mem[r][l] <= data_wb[l*DW +: DW];
          end else if (w_a_sel[r] && mask_wa[l]) begin
            r_mem[r][l] <= data_wa[l*DW +: DW];
          end
        end
        // A new reservation outranks the late write that retires the old one.
        if (w_rsv_sel[r]) begin
          r_pend[r] <= 1'b1;
        end else if (w_b_sel[r]) begin
          r_pend[r] <= 1'b0;
        end
      end
    end
  end

  assign rsv_conflict = rsv_en && f_ok(rsv_addr) && r_pend[rsv_addr]
                     && !(wen_b && (addr_wb == rsv_addr));

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic          w_ok;
    logic          w_bhit;
    logic          w_ahit;

    assign w_ra   = addr_r[k*AW +: AW];
    assign w_ok   = f_ok(w_ra);
    assign w_bhit = wen_b && (addr_wb == w_ra);
    assign w_ahit = wen_a && (addr_wa == w_ra);

    assign busy_r[k] = w_ok && r_pend[w_ra] && !w_bhit;

    for (genvar l = 0; l < VLEN; l++) begin : g_ln
      assign data_r[(k*VLEN+l)*DW +: DW] =
        !w_ok                   ? '0 :
        (w_bhit && mask_wb[l])  ? data_wb[l*DW +: DW] :
        (w_ahit && mask_wa[l])  ? data_wa[l*DW +: DW] :
                                  r_mem[w_ra][l];
    end
  end

endmodule

// File: tb/tb_vregfile_sb.sv
// Directed and random checks of vregfile_sb against a lane-level
// reference model of storage, bypass and the pending scoreboard.
module tb_vregfile_sb;

  localparam int DW     = 32;
  localparam int VLEN   = 16;
  localparam int AW     = 5;
  localparam int DEPTH  = 32;
  localparam int NRD    = 3;
  localparam int ZREG   = 1;
  localparam int VW     = VLEN*DW;

  logic              clk;
  logic              rst_n;
  logic              wen_a;
  logic [AW-1:0]     addr_wa;
  logic [VLEN-1:0]   mask_wa;
  logic [VW-1:0]     data_wa;
  logic              wen_b;
  logic [AW-1:0]     addr_wb;
  logic [VLEN-1:0]   mask_wb;
  logic [VW-1:0]     data_wb;
  logic              rsv_en;
  logic [AW-1:0]     rsv_addr;
  logic              rsv_conflict;
  logic [NRD*AW-1:0] addr_r;
  logic [NRD*VW-1:0] data_r;
  logic [NRD-1:0]    busy_r;

  vregfile_sb #(
    .DATA_WIDTH(DW), .VLEN(VLEN), .ADDR_WIDTH(AW),
    .DEPTH(DEPTH), .NUM_RD(NRD), .ZERO_REG(ZREG)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wen_a(wen_a), .addr_wa(addr_wa), .mask_wa(mask_wa), .data_wa(data_wa),
    .wen_b(wen_b), .addr_wb(addr_wb), .mask_wb(mask_wb), .data_wb(data_wb),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_conflict(rsv_conflict),
    .addr_r(addr_r), .data_r(data_r), .busy_r(busy_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] m_mem [DEPTH][VLEN];
  bit            m_pend [DEPTH];
  int            n_chk  = 0;
  int            n_fail = 0;

  function automatic bit valid(input int a);
    return (a < DEPTH) && !(ZREG != 0 && a == 0);
  endfunction

  function automatic logic [VW-1:0] exp_rd(input int a);
    logic [VW-1:0] v;
    v = '0;
    if (!valid(a)) return v;
    for (int l = 0; l < VLEN; l++) begin
      v[l*DW +: DW] = m_mem[a][l];
      if (wen_a && int'(addr_wa) == a && mask_wa[l]) v[l*DW +: DW] = data_wa[l*DW +: DW];
      if (wen_b && int'(addr_wb) == a && mask_wb[l]) v[l*DW +: DW] = data_wb[l*DW +: DW];
    end
    return v;
  endfunction

  function automatic bit exp_busy(input int a);
    return valid(a) && m_pend[a] && !(wen_b && int'(addr_wb) == a);
  endfunction

  function automatic logic [DW-1:0] lane(input int k, input int l);
    return data_r[(k*VLEN+l)*DW +: DW];
  endfunction

  task automatic spot(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check(input string tag);
    logic [NRD-1:0] eb;
    int a;
    eb = '0;
    for (int k = 0; k < NRD; k++) begin
      a = int'(addr_r[k*AW +: AW]);
      eb[k] = exp_busy(a);
      spot($sformatf("%s data%0d", tag, k), data_r[k*VW +: VW], exp_rd(a));
    end
    spot({tag, " busy"}, VW'(busy_r), VW'(eb));
    spot({tag, " conflict"}, VW'(rsv_conflict),
         VW'(rsv_en && exp_busy(int'(rsv_addr))));
  endtask

  task automatic idle();
    wen_a = 0; addr_wa = '0; mask_wa = '0; data_wa = '0;
    wen_b = 0; addr_wb = '0; mask_wb = '0; data_wb = '0;
    rsv_en = 0; rsv_addr = '0;
  endtask

  task automatic rd_all(input int a);
    for (int k = 0; k < NRD; k++) addr_r[k*AW +: AW] = AW'(a);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic advance();
    @(posedge clk);
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        m_pend[r] = 0;
        for (int l = 0; l < VLEN; l++) m_mem[r][l] = '0;
      end
    end else begin
      if (wen_a && valid(int'(addr_wa)))
        for (int l = 0; l < VLEN; l++)
          if (mask_wa[l]) m_mem[addr_wa][l] = data_wa[l*DW +: DW];
      if (wen_b && valid(int'(addr_wb))) begin
        for (int l = 0; l < VLEN; l++)
          if (mask_wb[l]) m_mem[addr_wb][l] = data_wb[l*DW +: DW];
        m_pend[addr_wb] = 0;
      end
      if (rsv_en && valid(int'(rsv_addr))) m_pend[rsv_addr] = 1;
    end
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int r = 0; r < DEPTH; r++) begin
      m_pend[r] = 0;
      for (int l = 0; l < VLEN; l++) m_mem[r][l] = '0;
    end
    idle();
    rd_all(3);
    rst_n = 0;
    @(negedge clk);
    advance();
    advance();
    rst_n = 1;

    settle();
    check("reset");
    spot("reset data0", data_r[0 +: VW], '0);
    spot("reset busy", VW'(busy_r), '0);
    @(negedge clk);

    wen_a = 1; addr_wa = 3; mask_wa = 16'hFFFF;
    for (int l = 0; l < VLEN; l++) data_wa[l*DW +: DW] = DW'(l + 1);
    settle();
    check("wa3 bypass");
    spot("wa3 bypass lane0", VW'(lane(0, 0)), VW'(1));
    spot("wa3 bypass lane15", VW'(lane(0, 15)), VW'(16));
    advance();
    idle();
    settle();
    check("wa3 stored");
    spot("wa3 stored lane15", VW'(lane(0, 15)), VW'(16));
    advance();

    rd_all(5);
    wen_a = 1; addr_wa = 5; mask_wa = 16'h00FF;
    wen_b = 1; addr_wb = 5; mask_wb = 16'hFF80;
    for (int l = 0; l < VLEN; l++) begin
      data_wa[l*DW +: DW] = 32'hAAAA_AAAA;
      data_wb[l*DW +: DW] = 32'h5555_5555;
    end
    settle();
    check("merge bypass");
    spot("merge lane7", VW'(lane(1, 7)), VW'(32'h5555_5555));
    advance();
    idle();
    settle();
    check("merge stored");
    spot("merge stored lane6", VW'(lane(2, 6)), VW'(32'hAAAA_AAAA));
    spot("merge stored lane7", VW'(lane(2, 7)), VW'(32'h5555_5555));
    spot("merge stored lane8", VW'(lane(2, 8)), VW'(32'h5555_5555));
    advance();

    rd_all(7);
    rsv_en = 1; rsv_addr = 7;
    settle();
    check("rsv7 issue");
    advance();
    idle();
    settle();
    check("rsv7 pending");
    spot("rsv7 busy", VW'(busy_r), VW'(3'b111));
    advance();
    wen_b = 1; addr_wb = 7; mask_wb = 16'hFFFF;
    for (int l = 0; l < VLEN; l++) data_wb[l*DW +: DW] = 32'hC0DE_0000 + DW'(l);
    settle();
    check("wb7 clear");
    spot("wb7 busy", VW'(busy_r), '0);
    spot("wb7 lane3", VW'(lane(1, 3)), VW'(32'hC0DE_0003));
    advance();
    idle();
    settle();
    check("wb7 after");
    spot("wb7 after busy", VW'(busy_r), '0);
    advance();

    rd_all(9);
    rsv_en = 1; rsv_addr = 9;
    settle();
    check("rsv9 first");
    advance();
    wen_b = 1; addr_wb = 9; mask_wb = 16'h000F;
    data_wb = {VLEN{32'h0909_0909}};
    settle();
    check("rsv9 b2b");
    spot("rsv9 b2b conflict", VW'(rsv_conflict), '0);
    advance();
    idle();
    rsv_en = 1; rsv_addr = 9;
    settle();
    check("rsv9 again");
    spot("rsv9 still busy", VW'(busy_r), VW'(3'b111));
    spot("rsv9 conflict", VW'(rsv_conflict), VW'(1));
    advance();
    idle();
    wen_b = 1; addr_wb = 9; mask_wb = '0;
    settle();
    check("rsv9 drain");
    advance();
    idle();

    rd_all(0);
    wen_a = 1; addr_wa = 0; mask_wa = 16'hFFFF; data_wa = '1;
    wen_b = 1; addr_wb = 0; mask_wb = 16'hFFFF; data_wb = '1;
    rsv_en = 1; rsv_addr = 0;
    settle();
    check("zero write");
    spot("zero data", data_r[0 +: VW], '0);
    spot("zero conflict", VW'(rsv_conflict), '0);
    advance();
    idle();
    settle();
    check("zero after");
    spot("zero after busy", VW'(busy_r), '0);
    advance();

    rd_all(4);
    rsv_en = 1; rsv_addr = 4;
    wen_a = 1; addr_wa = 4; mask_wa = 16'hFFFF; data_wa = {VLEN{32'h4444_4444}};
    settle();
    check("r4 setup");
    advance();
    idle();
    rst_n = 0;
    wen_a = 1; addr_wa = 4; mask_wa = 16'hFFFF; data_wa = {VLEN{32'h1234_5678}};
    rsv_en = 1; rsv_addr = 4;
    advance();
    idle();
    rst_n = 1;
    settle();
    check("midreset");
    spot("midreset data", data_r[0 +: VW], '0);
    spot("midreset busy", VW'(busy_r), '0);
    advance();

    for (int c = 0; c < 400; c++) begin
      rst_n    = ($urandom_range(0, 59) != 0);
      wen_a    = 1'($urandom);
      addr_wa  = AW'($urandom_range(0, 11));
      mask_wa  = VLEN'($urandom);
      wen_b    = 1'($urandom);
      addr_wb  = AW'($urandom_range(0, 11));
      mask_wb  = VLEN'($urandom);
      rsv_en   = ($urandom_range(0, 2) == 0);
      rsv_addr = AW'($urandom_range(0, 11));
      for (int l = 0; l < VLEN; l++) begin
        data_wa[l*DW +: DW] = $urandom;
        data_wb[l*DW +: DW] = $urandom;
      end
      for (int k = 0; k < NRD; k++) addr_r[k*AW +: AW] = AW'($urandom_range(0, 11));
      settle();
      if (rst_n) check("random");
      advance();
    end

    rst_n = 1;
    idle();
    for (int a = 0; a < 12; a++) begin
      rd_all(a);
      settle();
      check("final sweep");
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
